incdec_sched: RTL and testbench
===============================

# incdec_sched

Round-robin scheduler that shares one external `inc_dec` unit (in/op/out, combinational) among up to NREQ requesters: PC, SP, index and address-fixup paths. It accepts at most one increment/decrement request per cycle, drives the shared unit from a registered operand stage, and returns a registered, tagged result with a wrap flag. It sits between the CPU control unit's register-update paths and the single incrementer instance.

## Interface
- NBIT, 16, operand/result width; must match the shared unit.
- NREQ, 4, number of requesters, 2..8; IDW = clog2(NREQ).
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hold  in  1  global stall (CPU RDY low); freezes all state.
- req_valid  in  NREQ  per-requester request.
- req_op  in  NREQ  per-requester op: 1 = increment, 0 = decrement.
- req_data  in  NREQ*NBIT  operands; requester i uses bits [i*NBIT +: NBIT].
- req_ready  out  NREQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i].
- iu_in  out  NBIT  operand to the shared unit.
- iu_op  out  1  op to the shared unit.
- iu_out  in  NBIT  result from the shared unit.
- rsp_valid  out  1  result valid.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_data  out  NBIT  result.
- rsp_wrap  out  1  1 when the result wrapped: inc of all-ones or dec of zero.

## Operation
- State: rr_ptr (IDW bits), stage {s_vld, s_id, s_op, s_data}, response {rsp_valid, rsp_id, rsp_data, rsp_wrap}.
- Reset values: rr_ptr=0, s_vld=0, s_id=0, s_op=0, s_data=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_wrap=0. Reset asserted mid-operation discards the in-flight stage and response with no partial output.
- Arbitration (combinational):
  - Search req_valid starting at rr_ptr and wrapping modulo NREQ; the first set bit wins.
  - req_ready = one-hot of the winner when hold=0, otherwise 0. req_ready may depend on req_valid.
  - Requesters must not combinationally tie req_valid to req_ready.
- Accept edge (hold=0):
  - Winner w present: stage <= {1, w, req_op[w], req_data[w]}, and rr_ptr <= (w+1) mod NREQ.
  - No winner: s_vld <= 0, and rr_ptr is unchanged.
- Execute:
  - iu_in = s_data and iu_op = s_op, combinationally from the stage. Both are driven regardless of s_vld.
  - On the next edge with hold=0: rsp_valid <= s_vld, rsp_id <= s_id, rsp_data <= iu_out.
  - rsp_wrap <= s_vld & (s_op ? s_data=={NBIT{1}} : s_data==0).
  - When s_vld=0, rsp_id, rsp_data and rsp_wrap still load but are don't-care.
- Hold:
  - hold=1 freezes rr_ptr, stage and response registers and forces req_ready=0.
  - Outputs keep their values; consumers sample a response only when hold=0.
  - A response is consumed exactly once: in the first hold=0 cycle in which it is visible.
- Wrap arithmetic is modulo 2^NBIT; rsp_wrap is computed locally and does not depend on iu_out.
- No forwarding. A requester issuing a dependent operation must wait for its own rsp_valid.

## Timing
- Throughput: one operation per cycle, back-to-back, from any mix of requesters.
- Latency: request accepted at edge E; result in the registered outputs after edge E+1. So rsp_valid is high in the cycle following E+1, provided hold=0 at E+1.
- If hold is high at E+1, the result appears after the first subsequent hold=0 edge.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once per NREQ cycles, in order rr_ptr, rr_ptr+1, ….
- iu_in/iu_op change only on clock edges, because they come from registers. The path to the shared unit is therefore stage-register → inc_dec → response register, one full cycle.

## Test plan
- Reset: rst_n=0 asynchronously mid-stream, with no clk edge → all outputs 0, req_ready=0 while no valids. First grant after release goes to requester 0.
- Single op: req 2 valid, op=1, data 16'h12FF accepted at edge E → at E+1 rsp_valid=1, rsp_id=2, rsp_data=16'h1300, rsp_wrap=0, iu_op=1. rsp_valid=0 the following cycle.
- Wrap: req 0 dec of 16'h0000 → rsp_data=16'hFFFF, rsp_wrap=1. Req 1 inc of 16'hFFFF → rsp_data=16'h0000, rsp_wrap=1.
- Round-robin: all four valid continuously with data = id*16'h100 →
  - grants ordered 0,1,2,3,0,….
  - rsp_id follows the same order, two cycles later, with no bubbles.
  - Each rsp_data equals data ± 1.
- Hold:
  - Assert hold for 3 cycles while one op is in stage and one in response → req_ready=0, outputs frozen.
  - After release the frozen response is consumed, then the staged op completes the next cycle. Nothing is lost or duplicated.
- Sparse traffic: req 3 only, valid every other cycle → rr_ptr wraps 3→0 and req 3 is still granted immediately each time. rsp_valid alternates 1/0.

Source files
------------

// File: rtl/incdec_sched_if.sv
// Requester/response bus of the incdec_sched scheduler.
// The master side belongs to the requesters, the slave side to the scheduler.
interface incdec_sched_if #(
  parameter int NBIT = 16,
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_op;
  logic [NREQ*NBIT-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [NBIT-1:0]      rsp_data;
  logic                 rsp_wrap;

  modport master (
    output req_valid, req_op, req_data,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_wrap
  );

  modport slave (
    input  req_valid, req_op, req_data,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_wrap
  );
endinterface

// File: rtl/incdec_sched.sv
// Round-robin scheduler sharing one combinational inc/dec unit among NREQ requesters.
// Pipeline: grant -> operand stage register -> shared unit -> tagged response register.
module incdec_sched #(
  parameter int NBIT = 16,
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  incdec_sched_if.slave   bus,
  output logic [NBIT-1:0] iu_in,
  output logic            iu_op,
  input  logic [NBIT-1:0] iu_out
);
  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]  rr_ptr;
  logic            s_vld;
  logic [IDW-1:0]  s_id;
  logic            s_op;
  logic [NBIT-1:0] s_data;

  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic [NBIT-1:0] rsp_data;
  logic            rsp_wrap;

  logic            win_vld;
  logic [IDW-1:0]  win_id;
  logic            win_op;
  logic [NBIT-1:0] win_data;
  logic [IDW-1:0]  nxt_ptr;
  logic [IDW:0]    sum;
  logic [NREQ-1:0] ready;
  logic            s_wrap;

  // Search starts at rr_ptr and wraps modulo NREQ, which need not be a power of two.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    sum     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ))
        sum = sum - (IDW+1)'(NREQ);
      if (!win_vld && bus.req_valid[sum[IDW-1:0]]) begin
        win_vld = 1'b1;
        win_id  = sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    win_op   = 1'b0;
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) begin
        win_op   = bus.req_op[i];
        win_data = bus.req_data[i*NBIT +: NBIT];
      end
    end
  end

  always_comb begin
    nxt_ptr = (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;
    ready   = '0;
    if (win_vld && !hold)
      ready[win_id] = 1'b1;
  end

  assign s_wrap = s_vld & (s_op ? (&s_data) : ~(|s_data));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      s_vld  <= 1'b0;
      s_id   <= '0;
      s_op   <= 1'b0;
      s_data <= '0;
    end else if (!hold) begin
      s_vld <= win_vld;
      if (win_vld) begin
        s_id   <= win_id;
        s_op   <= win_op;
        s_data <= win_data;
        rr_ptr <= nxt_ptr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_wrap  <= 1'b0;
    end else if (!hold) begin
      rsp_valid <= s_vld;
      rsp_id    <= s_id;
      rsp_data  <= iu_out;
      rsp_wrap  <= s_wrap;
    end
  end

  assign iu_in         = s_data;
  assign iu_op         = s_op;
  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_wrap  = rsp_wrap;
endmodule

// File: tb/tb_incdec_sched.sv
// Directed bench for incdec_sched: stimulus pushes expected responses into a
// scoreboard queue; an independent monitor pops and compares each response.
module tb_incdec_sched;
  localparam int NBIT = 16;
  localparam int NREQ = 4;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
    logic        wrap;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            hold;
  logic [NBIT-1:0] iu_in;
  logic            iu_op;
  logic [NBIT-1:0] iu_out;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  incdec_sched_if #(.NBIT(NBIT), .NREQ(NREQ)) bus ();

  incdec_sched #(.NBIT(NBIT), .NREQ(NREQ)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (hold),
    .bus    (bus),
    .iu_in  (iu_in),
    .iu_op  (iu_op),
    .iu_out (iu_out)
  );

  // Shared inc/dec unit living outside the scheduler.
  assign iu_out = iu_op ? iu_in + 16'd1 : iu_in - 16'd1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock cycle of stimulus; g is the hand-computed expected grant (-1 = none).
  task automatic cycle(input logic h, input logic [3:0] v, input logic [3:0] op,
                       input logic [63:0] d, input int g);
    exp_t        e;
    logic [15:0] x;
    logic [3:0]  exp_rdy;
    hold          = h;
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_data  = d;
    @(negedge clk);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("grant", {28'd0, bus.req_ready}, {28'd0, exp_rdy});
    if (g >= 0) begin
      x      = d[g*16 +: 16];
      e.id   = 2'(g);
      e.data = op[g] ? x + 16'd1 : x - 16'd1;
      e.wrap = op[g] ? (x == 16'hFFFF) : (x == 16'h0000);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'b0000, 4'b0000, 64'd0, -1);
  endtask

  // Monitor: a response is consumed in each hold=0 cycle it is visible.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !hold && bus.rsp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected actual id=%0d data=%0h required none",
                   bus.rsp_id, bus.rsp_data);
        end else begin
          e = sb.pop_front();
          chk("rsp_id",   {30'd0, bus.rsp_id},   {30'd0, e.id});
          chk("rsp_data", {16'd0, bus.rsp_data}, {16'd0, e.data});
          chk("rsp_wrap", {31'd0, bus.rsp_wrap}, {31'd0, e.wrap});
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    hold          = 1'b0;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_data  = '0;
    #3;
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data",  {16'd0, bus.rsp_data},  32'd0);
    chk("rst_iu_in",     {16'd0, iu_in},         32'd0);
    chk("rst_ready",     {28'd0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single increment by requester 2.
    cycle(1'b0, 4'b0100, 4'b0100, {16'h0, 16'h12FF, 16'h0, 16'h0}, 2);
    chk("stage_iu_in", {16'd0, iu_in}, 32'h12FF);
    chk("stage_iu_op", {31'd0, iu_op}, 32'd1);
    idle(1);
    chk("single_valid", {31'd0, bus.rsp_valid}, 32'd1);
    idle(1);
    chk("single_gone", {31'd0, bus.rsp_valid}, 32'd0);

    // Wrap cases: rr_ptr=3, so req 0 wins first, then req 1.
    cycle(1'b0, 4'b0011, 4'b0010, {16'h0, 16'h0, 16'hFFFF, 16'h0000}, 0);
    cycle(1'b0, 4'b0010, 4'b0010, {16'h0, 16'h0, 16'hFFFF, 16'h0000}, 1);
    idle(2);

    // Sparse traffic from req 3; rr_ptr wraps 3->0 and req 3 still wins at once.
    cycle(1'b0, 4'b1000, 4'b1000, {16'h7FFF, 48'd0}, 3);
    idle(1);
    chk("sparse_v1", {31'd0, bus.rsp_valid}, 32'd1);
    cycle(1'b0, 4'b1000, 4'b0000, {16'h8000, 48'd0}, 3);
    chk("sparse_v0", {31'd0, bus.rsp_valid}, 32'd0);
    idle(1);
    chk("sparse_v2", {31'd0, bus.rsp_valid}, 32'd1);
    cycle(1'b0, 4'b1000, 4'b1000, {16'h00FF, 48'd0}, 3);
    chk("sparse_v3", {31'd0, bus.rsp_valid}, 32'd0);
    idle(1);
    chk("sparse_v4", {31'd0, bus.rsp_valid}, 32'd1);
    idle(1);

    // Round-robin with all requesters valid; rr_ptr is now 0.
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 4'b1111, 4'b0101, {16'h0300, 16'h0200, 16'h0100, 16'h0000}, k % 4);
      if (k >= 1) chk("rr_no_bubble", {31'd0, bus.rsp_valid}, 32'd1);
    end
    idle(2);

    // Hold with one op in the response register and one in the stage.
    cycle(1'b0, 4'b0001, 4'b0001, {48'd0, 16'h1234}, 0);
    cycle(1'b0, 4'b0010, 4'b0000, {32'd0, 16'h5678, 16'h0}, 1);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 4'b1111, 4'b1111, 64'd0, -1);
      chk("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("hold_id",    {30'd0, bus.rsp_id},    32'd0);
      chk("hold_data",  {16'd0, bus.rsp_data},  32'h1235);
      chk("hold_iu_in", {16'd0, iu_in},         32'h5678);
      chk("hold_iu_op", {31'd0, iu_op},         32'd0);
    end
    idle(1);
    chk("post_hold_id",   {30'd0, bus.rsp_id},   32'd1);
    chk("post_hold_data", {16'd0, bus.rsp_data}, 32'h5677);
    idle(1);
    chk("post_hold_gone", {31'd0, bus.rsp_valid}, 32'd0);

    // Asynchronous reset with ops in flight (rr_ptr=2 here).
    cycle(1'b0, 4'b0100, 4'b0100, {16'h0, 16'h4444, 32'd0}, 2);
    cycle(1'b0, 4'b1000, 4'b1000, {16'h5555, 48'd0}, 3);
    bus.req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("mid_rst_id",    {30'd0, bus.rsp_id},    32'd0);
    chk("mid_rst_data",  {16'd0, bus.rsp_data},  32'd0);
    chk("mid_rst_wrap",  {31'd0, bus.rsp_wrap},  32'd0);
    chk("mid_rst_iu_in", {16'd0, iu_in},         32'd0);
    chk("mid_rst_iu_op", {31'd0, iu_op},         32'd0);
    chk("mid_rst_ready", {28'd0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 4'b1111, 4'b0000, {16'h0300, 16'h0200, 16'h0100, 16'h0000}, 0);
    idle(3);

    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
